// File: rtl/ifm_sched.sv
// ifm_sched: walks the 3x3 convolution windows of one input feature map plane
// in serpentine order. It issues one strip read per PE-ready cycle and turns
// each read into a window-buffer shift command one cycle later.
//
// Handshake: a read (and therefore a window move) issues in a cycle only when
// pe_ready=1 in that same cycle. rd_en is a same-cycle strobe with no retry or
// backpressure. In a cycle with pe_ready=0 nothing issues and the scan
// position stays put. mode follows rd_en by one cycle, and win_valid follows a
// non-HOLD mode by one cycle.
module ifm_sched #(
  parameter int IMG_W   = 5,
  parameter int IMG_H   = 5,
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pe_ready,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [COORD_W-1:0] rd_row,
  output logic [COORD_W-1:0] rd_col,
  output logic [2:0]         rd_kind,
  output logic [2:0]         mode,
  output logic               win_valid,
  output logic [15:0]        win_cnt,
  output logic [1:0]         fsm_state
);

  localparam int OH = IMG_H - 2;
  localparam int OW = IMG_W - 2;
  localparam logic [15:0]        TOTAL    = 16'(OH * OW);
  localparam logic [15:0]        CNT_LAST = 16'(OH * OW - 1);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(OW - 1);
  localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);

  localparam logic [2:0] K_ALL   = 3'b111;
  localparam logic [2:0] K_RIGHT = 3'b001;
  localparam logic [2:0] K_DOWN  = 3'b010;
  localparam logic [2:0] K_LEFT  = 3'b100;
  localparam logic [2:0] K_HOLD  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SCAN  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state, state_d;

  // Current window position (top-left corner of the 3x3 window).
  logic [COORD_W-1:0] row_q, col_q, row_d, col_d;
  logic [2:0]         mode_q;
  logic               win_valid_q;
  logic [15:0]        win_cnt_q;

  assign busy      = (state != S_IDLE);
  assign mode      = mode_q;
  assign win_valid = win_valid_q;
  assign win_cnt   = win_cnt_q;
  assign fsm_state = state;

  // Next state, move selection and read strobe/strip coordinates.
  always_comb begin
    state_d = state;
    row_d   = row_q;
    col_d   = col_q;
    rd_en   = 1'b0;
    rd_row  = '0;
    rd_col  = '0;
    rd_kind = K_HOLD;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (pe_ready) begin
          rd_en   = 1'b1;
          rd_kind = K_ALL;
          row_d   = '0;
          col_d   = '0;
          // A single-window plane has nothing left to move through.
          state_d = (TOTAL == 16'd1) ? S_DRAIN : S_SCAN;
        end
      end
      S_SCAN: begin
        if (pe_ready) begin
          rd_en = 1'b1;
          if (!row_q[0] && (col_q != COL_LAST)) begin
            // Even row, still room to the right.
            rd_kind = K_RIGHT;
            col_d   = col_q + 1'b1;
            rd_row  = row_q;
            rd_col  = col_d + TWO;
          end else if (row_q[0] && (col_q != '0)) begin
            // Odd row, still room to the left.
            rd_kind = K_LEFT;
            col_d   = col_q - 1'b1;
            rd_row  = row_q;
            rd_col  = col_d;
          end else begin
            // End of a row: step down, the new bottom row is the strip.
            rd_kind = K_DOWN;
            row_d   = row_q + 1'b1;
            rd_row  = row_d + TWO;
            rd_col  = col_q;
          end
          if (win_cnt_q == CNT_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Finished once the last move has left both pipeline stages.
        if ((mode_q == K_HOLD) && !win_valid_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Scan position, shift-command pipeline and window counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      mode_q      <= K_HOLD;
      win_valid_q <= 1'b0;
      win_cnt_q   <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      mode_q      <= rd_en ? rd_kind : K_HOLD;
      win_valid_q <= (mode_q != K_HOLD);
      if ((state == S_IDLE) && start)
        win_cnt_q <= '0;
      else if (rd_en && (win_cnt_q != TOTAL))
        win_cnt_q <= win_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_ifm_sched.sv
// Bench for ifm_sched: five instances with different plane sizes share clock,
// reset and pe_ready. Each scan is checked cycle by cycle against a read list
// built from the serpentine window order.
module tb_ifm_sched;

  localparam logic [2:0] K_ALL   = 3'b111;
  localparam logic [2:0] K_RIGHT = 3'b001;
  localparam logic [2:0] K_DOWN  = 3'b010;
  localparam logic [2:0] K_LEFT  = 3'b100;
  localparam logic [2:0] K_HOLD  = 3'b101;

  localparam int W_TAB[5] = '{5, 3, 3, 6, 6};
  localparam int H_TAB[5] = '{5, 5, 3, 4, 3};

  // Clock / reset / shared inputs.
  logic clk = 1'b0;
  logic rst;
  logic pe_ready;
  always #5 clk = ~clk;

  logic        start_v[5];
  logic        busy_v[5], done_v[5], rd_en_v[5], win_valid_v[5];
  logic [7:0]  rd_row_v[5], rd_col_v[5];
  logic [2:0]  rd_kind_v[5], mode_v[5];
  logic [15:0] win_cnt_v[5];
  logic [1:0]  fsm_v[5];

  ifm_sched #(.IMG_W(5), .IMG_H(5), .COORD_W(8)) u_d0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .pe_ready(pe_ready),
    .busy(busy_v[0]), .done(done_v[0]), .rd_en(rd_en_v[0]),
    .rd_row(rd_row_v[0]), .rd_col(rd_col_v[0]), .rd_kind(rd_kind_v[0]),
    .mode(mode_v[0]), .win_valid(win_valid_v[0]), .win_cnt(win_cnt_v[0]),
    .fsm_state(fsm_v[0]));
  ifm_sched #(.IMG_W(3), .IMG_H(5), .COORD_W(8)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .pe_ready(pe_ready),
    .busy(busy_v[1]), .done(done_v[1]), .rd_en(rd_en_v[1]),
    .rd_row(rd_row_v[1]), .rd_col(rd_col_v[1]), .rd_kind(rd_kind_v[1]),
    .mode(mode_v[1]), .win_valid(win_valid_v[1]), .win_cnt(win_cnt_v[1]),
    .fsm_state(fsm_v[1]));
  ifm_sched #(.IMG_W(3), .IMG_H(3), .COORD_W(8)) u_d2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .pe_ready(pe_ready),
    .busy(busy_v[2]), .done(done_v[2]), .rd_en(rd_en_v[2]),
    .rd_row(rd_row_v[2]), .rd_col(rd_col_v[2]), .rd_kind(rd_kind_v[2]),
    .mode(mode_v[2]), .win_valid(win_valid_v[2]), .win_cnt(win_cnt_v[2]),
    .fsm_state(fsm_v[2]));
  ifm_sched #(.IMG_W(6), .IMG_H(4), .COORD_W(8)) u_d3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .pe_ready(pe_ready),
    .busy(busy_v[3]), .done(done_v[3]), .rd_en(rd_en_v[3]),
    .rd_row(rd_row_v[3]), .rd_col(rd_col_v[3]), .rd_kind(rd_kind_v[3]),
    .mode(mode_v[3]), .win_valid(win_valid_v[3]), .win_cnt(win_cnt_v[3]),
    .fsm_state(fsm_v[3]));
  ifm_sched #(.IMG_W(6), .IMG_H(3), .COORD_W(8)) u_d4 (
    .clk(clk), .rst(rst), .start(start_v[4]), .pe_ready(pe_ready),
    .busy(busy_v[4]), .done(done_v[4]), .rd_en(rd_en_v[4]),
    .rd_row(rd_row_v[4]), .rd_col(rd_col_v[4]), .rd_kind(rd_kind_v[4]),
    .mode(mode_v[4]), .win_valid(win_valid_v[4]), .win_cnt(win_cnt_v[4]),
    .fsm_state(fsm_v[4]));

  // Scoreboard: expected read list of the current scan.
  logic [2:0] exp_kind_q[$];
  logic [7:0] exp_row_q[$];
  logic [7:0] exp_col_q[$];

  int    n_err = 0;
  int    n_chk = 0;
  string cur_test = "reset";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0d expected %0d", cur_test, tag, obs, exp);
    end
  endtask

  // Reads implied by visiting the windows in serpentine order: the first is the
  // full 3x3 block, each later one is the strip entering the new window.
  task automatic build_model(input int w, input int h);
    int oh, ow, r, c, pr, pc;
    exp_kind_q.delete(); exp_row_q.delete(); exp_col_q.delete();
    oh = h - 2; ow = w - 2; pr = 0; pc = 0;
    for (int idx = 0; idx < oh * ow; idx++) begin
      r = idx / ow;
      c = (r % 2 == 0) ? (idx % ow) : (ow - 1 - (idx % ow));
      if (idx == 0) begin
        exp_kind_q.push_back(K_ALL); exp_row_q.push_back(8'd0); exp_col_q.push_back(8'd0);
      end else if (r != pr) begin
        exp_kind_q.push_back(K_DOWN); exp_row_q.push_back(8'(r + 2)); exp_col_q.push_back(8'(c));
      end else if (c > pc) begin
        exp_kind_q.push_back(K_RIGHT); exp_row_q.push_back(8'(r)); exp_col_q.push_back(8'(c + 2));
      end else begin
        exp_kind_q.push_back(K_LEFT); exp_row_q.push_back(8'(r)); exp_col_q.push_back(8'(c));
      end
      pr = r; pc = c;
    end
  endtask

  // Driver + per-cycle checks for one scan. Cycle 0 carries the start pulse.
  // rdy_mode: 0 always ready, 1 not ready in cycles 4-5, 2 random.
  task automatic run_scan(input int d, input int rdy_mode, input bit inject,
                          input int exp_done_cyc, input int abort_cyc, input bit tail);
    int n, nr, last_rd;
    bit prev_rd, prev_mode_act, rdy, exp_rd, exp_done, fin;
    logic [2:0] prev_kind;
    build_model(W_TAB[d], H_TAB[d]);
    n = exp_kind_q.size();
    nr = 0; last_rd = -100; prev_rd = 0; prev_mode_act = 0; prev_kind = K_HOLD; fin = 0;
    for (int k = 0; k < 300 && !fin; k++) begin
      exp_done = (nr == n) && (k == last_rd + 3);
      @(negedge clk);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = !(k == 4 || k == 5);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      pe_ready   = rdy;
      start_v[d] = (k == 0) || (inject && k >= 1 && !exp_done && $urandom_range(0, 1) == 1);
      rst        = (k == abort_cyc);
      #1;
      exp_rd = (k >= 1) && (nr < n) && rdy;
      chk("rd_en", rd_en_v[d], exp_rd);
      if (exp_rd) begin
        chk("rd_kind", rd_kind_v[d], exp_kind_q[nr]);
        chk("rd_row", rd_row_v[d], exp_row_q[nr]);
        chk("rd_col", rd_col_v[d], exp_col_q[nr]);
      end
      chk("mode", mode_v[d], prev_rd ? prev_kind : K_HOLD);
      chk("win_valid", win_valid_v[d], prev_mode_act);
      chk("done", done_v[d], exp_done);
      chk("busy", busy_v[d], k >= 1);
      if (k >= 1) chk("win_cnt", win_cnt_v[d], nr);
      prev_mode_act = prev_rd;
      prev_rd = exp_rd;
      if (exp_rd) begin
        prev_kind = exp_kind_q[nr];
        last_rd = k;
        nr++;
      end
      if (exp_done) begin
        fin = 1;
        if (exp_done_cyc >= 0) chk("done_cycle", k, exp_done_cyc);
      end
      if (k == abort_cyc) fin = 1;
    end
    if (!fin) chk("timeout", 0, 1);
    start_v[d] = 1'b0;
    if (abort_cyc >= 0) begin
      @(negedge clk);
      rst = 1'b0; pe_ready = 1'b1;
      #1;
      chk("rst_busy", busy_v[d], 0);
      chk("rst_done", done_v[d], 0);
      chk("rst_rd_en", rd_en_v[d], 0);
      chk("rst_rd_row", rd_row_v[d], 0);
      chk("rst_rd_col", rd_col_v[d], 0);
      chk("rst_rd_kind", rd_kind_v[d], K_HOLD);
      chk("rst_mode", mode_v[d], K_HOLD);
      chk("rst_win_valid", win_valid_v[d], 0);
      chk("rst_win_cnt", win_cnt_v[d], 0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        #1;
        chk("abort_no_done", done_v[d], 0);
        chk("abort_no_rd", rd_en_v[d], 0);
      end
    end
    if (tail) begin
      @(negedge clk);
      pe_ready = 1'b1;
      #1;
      chk("idle_busy", busy_v[d], 0);
      chk("idle_done", done_v[d], 0);
      chk("idle_rd_en", rd_en_v[d], 0);
      chk("idle_mode", mode_v[d], K_HOLD);
      chk("idle_win_cnt", win_cnt_v[d], n);
    end
  endtask

  // Directed sequence followed by randomized scans, then the report.
  initial begin
    rst = 1'b1; pe_ready = 1'b1;
    for (int i = 0; i < 5; i++) start_v[i] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 5; i++) chk("rst_fsm", fsm_v[i], 0);
    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    chk("rst_rd_en", rd_en_v[0], 0);
    chk("rst_rd_row", rd_row_v[0], 0);
    chk("rst_rd_col", rd_col_v[0], 0);
    chk("rst_rd_kind", rd_kind_v[0], K_HOLD);
    chk("rst_mode", mode_v[0], K_HOLD);
    chk("rst_win_valid", win_valid_v[0], 0);
    chk("rst_win_cnt", win_cnt_v[0], 0);
    rst = 1'b0;

    cur_test = "5x5_basic";    run_scan(0, 0, 0, 12, -1, 1);
    cur_test = "5x5_stall";    run_scan(0, 1, 0, 14, -1, 1);
    cur_test = "w3_h5";        run_scan(1, 0, 0, 6, -1, 1);
    cur_test = "3x3_first";    run_scan(2, 0, 0, 4, -1, 0);
    cur_test = "3x3_restart";  run_scan(2, 0, 0, 4, -1, 1);
    cur_test = "5x5_abort";    run_scan(0, 0, 0, -1, 5, 0);
    cur_test = "5x5_rescan";   run_scan(0, 0, 0, 12, -1, 1);
    cur_test = "5x5_inject";   run_scan(0, 0, 1, 12, -1, 1);
    cur_test = "h3_right";     run_scan(4, 0, 0, -1, -1, 1);
    for (int i = 0; i < 6; i++) begin
      cur_test = "rand_6x4";   run_scan(3, 2, 1, -1, -1, 1);
      cur_test = "rand_6x3";   run_scan(4, 2, 0, -1, -1, (i % 2) == 0);
      cur_test = "rand_5x5";   run_scan(0, 2, 1, -1, -1, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ifm_sched.md
IFM_SCHED -- requirements
Module: ifm_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 5, input feature map width in pixels; legal 3..255.
REQ-002 SHALL have parameter IMG_H, default 5, input feature map height in pixels; legal 3..255.
REQ-003 SHALL have parameter COORD_W, default 8, width of row/column coordinate outputs.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to scan one 3x3 convolution layer plane.
REQ-007 SHALL have port pe_ready  input  1  PE array can accept the next window this cycle.
REQ-008 SHALL have port busy  output  1  scan in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, scan complete.
REQ-010 SHALL have port rd_en  output  1  IFM memory read strobe, fixed 1-cycle read latency.
REQ-011 SHALL have port rd_row  output  COORD_W  top row of the requested strip.
REQ-012 SHALL have port rd_col  output  COORD_W  left column of the requested strip.
REQ-013 SHALL have port rd_kind  output  3  strip type of the read, same encoding as mode.
REQ-014 SHALL have port mode  output  3  window-buffer shift command: ALL=111, RIGHT=001, DOWN=010, LEFT=100, HOLD=101.
REQ-015 SHALL have port win_valid  output  1  3x3 window in the buffer is new and valid for the PE array.
REQ-016 SHALL have port win_cnt  output  16  number of windows issued since start.

Function
REQ-017 SHALL scan OH=IMG_H-2 by OW=IMG_W-2 window positions (r,c), stride 1, in serpentine order: even r left-to-right, odd r right-to-left, one DOWN move between rows.
REQ-018 SHALL use FSM states IDLE, LOAD, SCAN, DRAIN; IDLE->LOAD on start; LOAD->SCAN after the ALL read issues; SCAN->DRAIN after the last move issues; DRAIN->IDLE after done.
REQ-019 SHALL, in LOAD, issue rd_en with rd_kind=ALL at rd_row=0, rd_col=0 (3x3 block) when pe_ready=1, else wait.
REQ-020 SHALL, in SCAN, issue one move per cycle while pe_ready=1, with strip coordinates: RIGHT rd_row=r, rd_col=c_new+2; LEFT rd_row=r, rd_col=c_new; DOWN rd_row=r_new+2, rd_col=c.
REQ-021 SHALL hold rd_en=0 and all scan position registers unchanged in any cycle pe_ready=0.
REQ-022 SHALL drive mode = rd_kind delayed one cycle when rd_en was 1 the previous cycle, else HOLD.
REQ-023 SHALL assert win_valid exactly one cycle after each non-HOLD mode cycle.
REQ-024 SHALL increment win_cnt by 1 on each rd_en, saturating at OH*OW.
REQ-025 SHALL pulse done for one cycle, one cycle after the final win_valid, while staying in DRAIN; busy SHALL be high from the cycle after start is accepted through the done cycle inclusive.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL, for OW=1, issue only DOWN moves after ALL; for OH=1, issue only RIGHT moves; for OH=OW=1, issue ALL only, then DRAIN.
REQ-028 SHALL never issue a read outside rows 0..IMG_H-1 or columns 0..IMG_W-1.
REQ-029 SHALL allow start in the cycle after done to begin a new scan with win_cnt cleared to 0.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, return to IDLE and drive busy=0, done=0, rd_en=0, rd_row=0, rd_col=0, rd_kind=HOLD, mode=HOLD, win_valid=0, win_cnt=0.
REQ-031 SHALL abort a scan in progress on rst without issuing further reads or a done pulse.

Verification
REQ-032 SHALL verify 5x5, pe_ready=1, start at cycle 0 -> rd_en cycles 1-9, kinds ALL,R,R,D,L,L,D,R,R, (row,col) (0,0),(0,3),(0,4),(3,2),(1,1),(1,0),(4,0),(2,3),(2,4); win_valid cycles 3-11; done cycle 12; win_cnt=9.
REQ-033 SHALL verify pe_ready low cycles 4-5 in 5x5 -> no rd_en those cycles, mode=HOLD cycles 5-6, win_valid gaps, done at cycle 14.
REQ-034 SHALL verify IMG_W=3, IMG_H=5 -> kinds ALL,D,D; final read row 4, col 0; done after 3 windows.
REQ-035 SHALL verify IMG_W=IMG_H=3 -> single ALL read, one win_valid, done; then immediate restart works.
REQ-036 SHALL verify rst asserted at cycle 5 of a 5x5 scan -> next cycle all outputs at reset values, no done; start afterwards rescans from (0,0).
REQ-037 SHALL verify start pulses during busy -> ignored, sequence identical to REQ-032.
